sram_arbiter_bridge: RTL and testbench
======================================

// Module: sram_arbiter_bridge
// PURPOSE
//  Parametrised external-SRAM bridge for the pipelined MIPS core. Arbitrates the
//  IF-stage fetch port and the MEM-stage load/store port onto one asynchronous SRAM.
//  Supports native 32-bit or 16-bit (two-beat) SRAM and configurable wait states.
//  Drives a stall to the pipeline-control unit while an access is outstanding.
// PARAMETERS
//  ADDR_W      20  word-address bits taken from CPU byte address [ADDR_W+1:2]
//  SRAM_DW     32  SRAM data width; legal 32 or 16 (16 => BEATS=2, else BEATS=1)
//  WAIT_CYCLES 1   extra cycles per beat, >=1; beat length N = WAIT_CYCLES+1
//  DATA_PRIO   1   1: data port wins simultaneous requests; 0: fetch port wins
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst         in   1        asynchronous, active-high reset
//  inst_req    in   1        fetch request, held high until inst_ready
//  inst_addr   in   32       fetch byte address (bits [1:0] ignored)
//  inst_rdata  out  32       fetched word, valid when inst_ready
//  inst_ready  out  1        one-cycle completion pulse, fetch port
//  data_req    in   1        load/store request, held high until data_ready
//  data_we     in   1        1 = store, 0 = load
//  data_be     in   4        byte enables, bit i = byte lane i (little-endian)
//  data_addr   in   32       load/store byte address
//  data_wdata  in   32       store data
//  data_rdata  out  32       load data, full word, valid when data_ready
//  data_ready  out  1        one-cycle completion pulse, data port
//  cpu_stall   out  1        (inst_req&~inst_ready)|(data_req&~data_ready), combinational
//  sram_addr   out  ADDR_W+BEATS-1  SRAM address; 16-bit mode = {word_addr, beat}
//  sram_dq_o   out  SRAM_DW  write data to pad
//  sram_dq_i   in   SRAM_DW  read data from pad
//  sram_dq_oe  out  1        1 = bridge drives the data bus
//  sram_ce_n   out  1        chip enable, active low
//  sram_oe_n   out  1        output enable, active low
//  sram_we_n   out  1        write enable, active low
//  sram_be_n   out  SRAM_DW/8  byte-lane enables, active low
// BEHAVIOUR
//  Reset: FSM=IDLE; ce_n/oe_n/we_n=1; be_n all 1; dq_oe=0; sram_addr=0; dq_o=0.
//   Reset also clears ready pulses and rdata regs to 0. Asserting rst mid-access
//   aborts the access with no ready pulse; outputs go inactive immediately.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: on edge with any req, latch grant, addr, we, be, wdata; go ACCESS with beat=0, cnt=0.
//    Simultaneous reqs resolved by DATA_PRIO; loser stays pending, served next IDLE.
//   ACCESS: ce_n=0; addr/be_n/dq_o held for whole beat; cnt counts 0..N-1.
//    Read: oe_n=0, dq_oe=0; sram_dq_i sampled into lane(s) of rdata at cnt=N-1.
//    Write: dq_oe=1, oe_n=1; we_n=0 for cnt 0..N-2, 1 at cnt=N-1, so addr/data are
//     stable across the we_n rising edge.
//    16-bit mode: beat0 = bits[15:0] with be[1:0]; beat1 = bits[31:16] with be[3:2].
//     On a store, a beat whose two enables are both 0 is skipped, and a store with
//     be=0 performs no SRAM cycle. Loads always run both beats.
//    After last beat cnt=N-1 -> DONE.
//   DONE: all SRAM strobes inactive (turnaround cycle); granted port's ready=1 for
//    exactly this cycle; rdata holds until the next completion on that port.
//  Latency: req seen at edge k => ready high in cycle k+BEATS*N+1 (skipped beats removed).
//  Back-to-back: a new request is accepted earliest in the IDLE cycle after DONE.
//  Stores return data_ready; data_rdata unchanged on store completion.
//  Fetch port never writes; inst path ignores be (full word).
// STRUCTURE
//  Shared pkg/header sram_bridge_defs: FSM state encodings (IDLE/ACCESS/DONE), GRANT_INST/GRANT_DATA.
//  One sub-module: sram_beat_timer (cnt/beat counter, emits beat_last, access_last, we_n window).
// TESTING
//  1 SRAM_DW=32,WAIT=1: load @0x10, model returns 0x34010001 -> data_ready in cycle k+3, rdata=0x34010001.
//  2 SRAM_DW=16,WAIT=2: fetch @0x4, halves 0x0001/0x3402 -> sram_addr 2 then 3, inst_rdata=0x34020001 at k+7.
//  3 Same cycle inst_req+data_req, DATA_PRIO=1 -> data served first, inst_ready follows after one IDLE cycle.
//  4 SRAM_DW=16 store be=4'b1100 wdata=0xAABBCCDD -> only beat1: addr odd, dq_o=0xAABB, be_n=2'b00, we_n low WAIT cycles.
//  5 Store be=4'b0000 -> no ce_n low, data_ready one cycle after acceptance; cpu_stall drops with ready.
//  6 rst pulsed mid-ACCESS of a store -> we_n/ce_n=1 at once, no ready pulse, next request served normally.

Source files
------------

// File: rtl/sram_arbiter_bridge_pkg.sv
// sram_bridge_defs: shared FSM state and grant encodings for the SRAM bridge
package sram_bridge_defs;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;
  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;
  function automatic int beats_of(input int dw);
    return (dw == 16) ? 2 : 1;
  endfunction
endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: per-beat cycle counter and beat index for the SRAM access
module sram_beat_timer #(
  parameter int BEATS = 1,
  parameter int N     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_start_beat,
  input  logic i_run,
  input  logic i_skip_hi,
  output logic o_beat,
  output logic o_beat_last,
  output logic o_access_last,
  output logic o_we_win
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [CW-1:0] r_cnt;
  logic          r_beat;
  assign o_beat        = r_beat;
  assign o_beat_last   = r_cnt == LAST;
  assign o_access_last = o_beat_last && (r_beat || BEATS == 1 || i_skip_hi);
  assign o_we_win      = r_cnt != LAST;
  // count cycles within a beat and advance to the upper half after the lower one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_beat <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_beat <= i_start_beat;
    end else if (i_run) begin
      r_cnt  <= o_beat_last ? '0 : r_cnt + 1'b1;
      r_beat <= o_beat_last ? !o_access_last : r_beat;
    end
  end
endmodule

// File: rtl/sram_arbiter_bridge.sv
// sram_arbiter_bridge: arbitrates fetch and load/store ports onto one async SRAM
module sram_arbiter_bridge
  import sram_bridge_defs::*;
#(
  parameter int ADDR_W      = 20,
  parameter int SRAM_DW     = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_PRIO   = 1,
  localparam int BEATS      = beats_of(SRAM_DW),
  localparam int N          = WAIT_CYCLES + 1,
  localparam int BW         = SRAM_DW / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req,
  input  logic [31:0]             inst_addr,
  output logic [31:0]             inst_rdata,
  output logic                    inst_ready,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [3:0]              data_be,
  input  logic [31:0]             data_addr,
  input  logic [31:0]             data_wdata,
  output logic [31:0]             data_rdata,
  output logic                    data_ready,
  output logic                    cpu_stall,
  output logic [ADDR_W+BEATS-2:0] sram_addr,
  output logic [SRAM_DW-1:0]      sram_dq_o,
  input  logic [SRAM_DW-1:0]      sram_dq_i,
  output logic                    sram_dq_oe,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [BW-1:0]           sram_be_n
);
  state_t              r_state, w_next;
  grant_t              r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata, r_inst_rdata, r_data_rdata;
  logic [15:0]         r_lo;
  logic                w_any, w_gnt_data, w_idle, w_acc, w_start;
  logic                w_skip_all, w_start_beat, w_skip_hi;
  logic                w_beat, w_beat_last, w_access_last, w_we_win;
  logic [31:0]         w_word;
  logic [BW-1:0]       w_lane_be;
  logic [SRAM_DW-1:0]  w_lane_wd;
  logic                w_unused;
  assign w_any        = inst_req || data_req;
  assign w_gnt_data   = data_req && (DATA_PRIO != 0 || !inst_req);
  assign w_idle       = r_state == S_IDLE;
  assign w_acc        = r_state == S_ACCESS;
  assign w_start      = w_idle && w_any;
  assign w_skip_all   = w_gnt_data && data_we && data_be == 4'b0000;
  assign w_start_beat = BEATS == 2 && w_gnt_data && data_we && data_be[1:0] == 2'b00;
  assign w_skip_hi    = BEATS == 2 && r_we && r_be[3:2] == 2'b00;
  assign w_unused     = ^{inst_addr, data_addr, r_lo, w_beat};
  sram_beat_timer #(
    .BEATS(BEATS),
    .N    (N)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_start_beat (w_start_beat),
    .i_run        (w_acc),
    .i_skip_hi    (w_skip_hi),
    .o_beat       (w_beat),
    .o_beat_last  (w_beat_last),
    .o_access_last(w_access_last),
    .o_we_win     (w_we_win)
  );
  if (BEATS == 2) begin : g_half
    assign w_word    = {sram_dq_i, r_lo};
    assign w_lane_be = w_beat ? r_be[3:2] : r_be[1:0];
    assign w_lane_wd = w_beat ? r_wdata[31:16] : r_wdata[15:0];
    assign sram_addr = {r_addr, w_beat};
  end else begin : g_full
    assign w_word    = sram_dq_i;
    assign w_lane_be = r_be;
    assign w_lane_wd = r_wdata;
    assign sram_addr = r_addr;
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // FSM next state: a store with no enabled bytes goes straight to the completion cycle
  always_comb begin
    w_next = w_idle ? (w_any ? (w_skip_all ? S_DONE : S_ACCESS) : S_IDLE)
           : w_acc  ? (w_access_last ? S_DONE : S_ACCESS)
           : S_IDLE;
  end
  // latch the winning request; loads and fetches always enable every lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= GRANT_INST;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_grant <= w_gnt_data ? GRANT_DATA : GRANT_INST;
      r_addr  <= w_gnt_data ? data_addr[ADDR_W+1:2] : inst_addr[ADDR_W+1:2];
      r_we    <= w_gnt_data && data_we;
      r_be    <= (w_gnt_data && data_we) ? data_be : 4'hF;
      r_wdata <= data_wdata;
    end
  end
  // sample read data at the end of each beat; the port register only changes on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo         <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else if (w_acc && !r_we && w_beat_last) begin
      r_lo <= sram_dq_i[15:0];
      if (w_access_last && r_grant == GRANT_DATA) r_data_rdata <= w_word;
      if (w_access_last && r_grant == GRANT_INST) r_inst_rdata <= w_word;
    end
  end
  // FSM outputs: strobes only during ACCESS, we_n released in the last cycle of each beat
  always_comb begin
    sram_ce_n  = !w_acc;
    sram_oe_n  = !(w_acc && !r_we);
    sram_we_n  = !(w_acc && r_we && w_we_win);
    sram_dq_oe = w_acc && r_we;
    sram_be_n  = w_acc ? ~w_lane_be : '1;
    inst_ready = r_state == S_DONE && r_grant == GRANT_INST;
    data_ready = r_state == S_DONE && r_grant == GRANT_DATA;
  end
  assign sram_dq_o  = w_lane_wd;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign cpu_stall  = (inst_req && !inst_ready) || (data_req && !data_ready);
endmodule

// File: tb/tb_sram_arbiter_bridge.sv
// tb_sram_arbiter_bridge: 32-bit and 16-bit bridges against a word-level memory model
module tb_sram_arbiter_bridge;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] ireq = '0, dreq = '0;
  logic dwe = 1'b0;
  logic [3:0] dbe = '0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
  logic [1:0][31:0] ird, drd;
  logic [1:0] i_rdy, d_rdy, stall, oe, ce_n, oe_n, we_n;
  logic [19:0] sa0;
  logic [20:0] sa1;
  logic [31:0] dqo0, dqi0;
  logic [15:0] dqo1, dqi1;
  logic [3:0] ben0;
  logic [1:0] ben1;
  logic [31:0] mem0[64], mem1[64];
  logic [31:0] ref_m[2][64];
  logic [31:0] exp_ird[2], exp_drd[2];
  logic [63:0] alog[2][16];
  int ce_cnt[2] = '{0, 0};
  logic mem_init = 1'b0;
  int tests = 0, fails = 0;
  sram_arbiter_bridge #(.ADDR_W(20), .SRAM_DW(32), .WAIT_CYCLES(1), .DATA_PRIO(1)) u32 (
    .clk(clk), .rst(rst), .inst_req(ireq[0]), .inst_addr(iaddr), .inst_rdata(ird[0]),
    .inst_ready(i_rdy[0]), .data_req(dreq[0]), .data_we(dwe), .data_be(dbe), .data_addr(daddr),
    .data_wdata(dwdata), .data_rdata(drd[0]), .data_ready(d_rdy[0]), .cpu_stall(stall[0]),
    .sram_addr(sa0), .sram_dq_o(dqo0), .sram_dq_i(dqi0), .sram_dq_oe(oe[0]), .sram_ce_n(ce_n[0]),
    .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(ben0));
  sram_arbiter_bridge #(.ADDR_W(20), .SRAM_DW(16), .WAIT_CYCLES(2), .DATA_PRIO(0)) u16 (
    .clk(clk), .rst(rst), .inst_req(ireq[1]), .inst_addr(iaddr), .inst_rdata(ird[1]),
    .inst_ready(i_rdy[1]), .data_req(dreq[1]), .data_we(dwe), .data_be(dbe), .data_addr(daddr),
    .data_wdata(dwdata), .data_rdata(drd[1]), .data_ready(d_rdy[1]), .cpu_stall(stall[1]),
    .sram_addr(sa1), .sram_dq_o(dqo1), .sram_dq_i(dqi1), .sram_dq_oe(oe[1]), .sram_ce_n(ce_n[1]),
    .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(ben1));
  function automatic logic [31:0] iv(input int s, input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'(s * 7 + 1);
  endfunction
  assign dqi0 = mem0[sa0[5:0]];
  assign dqi1 = sa1[0] ? mem1[sa1[6:1]][31:16] : mem1[sa1[6:1]][15:0];
  // asynchronous SRAM devices plus a per-cycle log of the bus while ce_n is low
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < 64; w++) begin
        mem0[w] <= iv(0, w);
        mem1[w] <= iv(1, w);
      end
      mem_init <= 1'b1;
    end
    if (!ce_n[0] && !we_n[0])
      for (int b = 0; b < 4; b++) if (!ben0[b]) mem0[sa0[5:0]][8*b +: 8] <= dqo0[8*b +: 8];
    if (!ce_n[1] && !we_n[1])
      for (int b = 0; b < 2; b++) if (!ben1[b]) mem1[sa1[6:1]][16*sa1[0]+8*b +: 8] <= dqo1[8*b +: 8];
    if (!ce_n[0]) alog[0][ce_cnt[0] % 16] <= {we_n[0], oe_n[0], oe[0], 1'b0, ben0, dqo0, 4'b0, sa0};
    if (!ce_n[1]) alog[1][ce_cnt[1] % 16] <= {we_n[1], oe_n[1], oe[1], 1'b0, 2'b0, ben1, 16'b0, dqo1, 3'b0, sa1};
    ce_cnt[0] <= ce_cnt[0] + (ce_n[0] ? 0 : 1);
    ce_cnt[1] <= ce_cnt[1] + (ce_n[1] ? 0 : 1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one transaction on instance s, checked against the word-level reference memory
  task automatic xfer(input int s, input bit dp, input bit we, input logic [3:0] be, input int w, input logic [31:0] wd);
    int nb, n, c0, b, j, bl[2];
    int nn = (s == 0) ? 2 : 3;
    logic [63:0] e, o;
    logic [3:0] ebe;
    logic [31:0] edq;
    logic [23:0] esa;
    logic [31:0] a;
    bit wr;
    wr = dp && we;
    nb = 0;
    if (s == 0) begin
      if (!(wr && be == 4'b0)) begin bl[0] = 0; nb = 1; end
    end else begin
      for (int k = 0; k < 2; k++) if (!wr || be[2*k +: 2] != 2'b0) begin bl[nb] = k; nb++; end
    end
    a = {10'($urandom), 14'd0, 6'(w), 2'($urandom)};
    @(negedge clk);
    if (dp) begin dreq[s] = 1'b1; dwe = we; dbe = be; daddr = a; dwdata = wd; end
    else begin ireq[s] = 1'b1; iaddr = a; end
    c0 = ce_cnt[s];
    #1 chk("stall_on_req", 64'(stall[s]), 64'd1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (dp ? d_rdy[s] : i_rdy[s]) break;
    end
    chk("latency", 64'(n), 64'(nb * nn + 1));
    chk("ce_cycles", 64'(ce_cnt[s] - c0), 64'(nb * nn));
    chk("stall_at_ready", 64'(stall[s]), 64'd0);
    chk("other_ready", 64'(dp ? i_rdy[s] : d_rdy[s]), 64'd0);
    for (int i = 0; i < nb * nn; i++) begin
      b = bl[i / nn];
      j = i % nn;
      ebe = !wr ? 4'b0 : (s == 0) ? ~be : {2'b00, ~be[2*b +: 2]};
      edq = !wr ? 32'b0 : (s == 0) ? wd : {16'b0, wd[16*b +: 16]};
      esa = (s == 0) ? 24'(w) : 24'(w * 2 + b);
      e = {(wr ? (j == nn - 1) : 1'b1), wr, wr, 1'b0, ebe, edq, esa};
      o = alog[s][(c0 + i) % 16];
      if (!wr) o[55:24] = '0;
      chk("bus_cycle", o, e);
    end
    if (wr) for (int k = 0; k < 4; k++) if (be[k]) ref_m[s][w][8*k +: 8] = wd[8*k +: 8];
    if (dp && !we) exp_drd[s] = ref_m[s][w];
    if (!dp) exp_ird[s] = ref_m[s][w];
    chk("data_rdata", 64'(drd[s]), 64'(exp_drd[s]));
    chk("inst_rdata", 64'(ird[s]), 64'(exp_ird[s]));
    if (dp) dreq[s] = 1'b0; else ireq[s] = 1'b0;
  endtask
  // fetch and load raised in the same cycle; checks order and completion cycles
  task automatic dual(input int s, input int wi, input int wdw, input int exp_ti, input int exp_td);
    int ti, td;
    @(negedge clk);
    ireq[s] = 1'b1; iaddr = 32'(wi * 4);
    dreq[s] = 1'b1; dwe = 1'b0; dbe = 4'hF; daddr = 32'(wdw * 4);
    ti = 0; td = 0;
    for (int n = 1; n <= 60 && (ti == 0 || td == 0); n++) begin
      @(negedge clk);
      if (i_rdy[s] && ti == 0) begin
        ti = n;
        exp_ird[s] = ref_m[s][wi];
        chk("dual_inst_rdata", 64'(ird[s]), 64'(exp_ird[s]));
        chk("dual_stall", 64'(stall[s]), 64'(td == 0));
        ireq[s] = 1'b0;
      end
      if (d_rdy[s] && td == 0) begin
        td = n;
        exp_drd[s] = ref_m[s][wdw];
        chk("dual_data_rdata", 64'(drd[s]), 64'(exp_drd[s]));
        chk("dual_stall", 64'(stall[s]), 64'(ti == 0));
        dreq[s] = 1'b0;
      end
    end
    ireq[s] = 1'b0; dreq[s] = 1'b0;
    chk("dual_inst_cycle", 64'(ti), 64'(exp_ti));
    chk("dual_data_cycle", 64'(td), 64'(exp_td));
  endtask
  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) ref_m[s][w] = iv(s, w);
      exp_ird[s] = '0;
      exp_drd[s] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_strobes0", 64'({ce_n[0], oe_n[0], we_n[0], oe[0], ben0}), 64'h0E_F);
    chk("rst_strobes1", 64'({ce_n[1], oe_n[1], we_n[1], oe[1], ben1}), 64'b1110_11);
    chk("rst_bus0", 64'({sa0, dqo0}), 64'd0);
    chk("rst_bus1", 64'({sa1, dqo1}), 64'd0);
    chk("rst_out0", {ird[0], drd[0]} | 64'({i_rdy[0], d_rdy[0], stall[0]}), 64'd0);
    chk("rst_out1", {ird[1], drd[1]} | 64'({i_rdy[1], d_rdy[1], stall[1]}), 64'd0);
    rst = 1'b0;
    xfer(0, 1, 1, 4'hF, 4, 32'h34010001);
    xfer(0, 1, 0, 4'hF, 4, 32'h0);
    chk("load_0x10", 64'(drd[0]), 64'h34010001);
    xfer(1, 1, 1, 4'hF, 1, 32'h34020001);
    xfer(1, 0, 0, 4'h0, 1, 32'h0);
    chk("fetch_0x4", 64'(ird[1]), 64'h34020001);
    dual(0, 7, 8, 7, 3);
    dual(1, 9, 10, 7, 15);
    xfer(1, 1, 1, 4'b1100, 12, 32'hAABBCCDD);
    xfer(1, 1, 1, 4'b0011, 13, 32'h11223344);
    xfer(1, 1, 0, 4'b0000, 12, 32'h0);
    xfer(0, 1, 1, 4'b0000, 5, 32'hDEADBEEF);
    xfer(1, 1, 1, 4'b0000, 5, 32'hDEADBEEF);
    @(negedge clk);
    dreq[1] = 1'b1; dwe = 1'b1; dbe = 4'hF; daddr = 32'(60 * 4); dwdata = $urandom;
    @(negedge clk);
    chk("abort_we_active", 64'({ce_n[1], we_n[1]}), 64'd0);
    rst = 1'b1;
    #1 chk("abort_strobes", 64'({ce_n[1], we_n[1], oe[1], d_rdy[1]}), 64'b1100);
    @(negedge clk);
    dreq[1] = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin exp_ird[s] = '0; exp_drd[s] = '0; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 64'({i_rdy, d_rdy}), 64'd0);
    end
    chk("abort_rdata_clr", 64'(drd[1]), 64'd0);
    xfer(1, 1, 0, 4'hF, 4, 32'h0);
    for (int s = 0; s < 2; s++)
      for (int t = 0; t < 40; t++) begin
        bit dp;
        dp = 1'($urandom);
        xfer(s, dp, dp & 1'($urandom), 4'($urandom), int'($urandom_range(0, 47)), $urandom);
      end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
